seq_chk_multi: RTL
==================

Name: seq_chk_multi

Overview:
- Synthesizable multi-channel checker for the protocol sequence "start |=> x[*X_LEN] ##[1:Y_WIN] y".
- Replaces hand-written, single-shape SVA checks with a parametrised RTL monitor.
- Usable in benches and as on-chip protocol-violation detection.
- Each channel independently reports one registered pass/fail pulse per accepted attempt.

Parameters:
- NUM_CH, 1, number of independent channels.
- X_LEN, 2, consecutive cycles x must be high after the start cycle; X_LEN >= 1.
- Y_WIN, 1, window in cycles after the last x in which y must rise; Y_WIN >= 1. Y_WIN=1 reproduces "x ##1 x ##1 y".
- CNT_W, 16, width of the statistic counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  NUM_CH  per-channel attempt trigger.
- x  in  NUM_CH  per-channel repeated-phase signal.
- y  in  NUM_CH  per-channel completion signal.
- busy  out  NUM_CH  channel has an attempt in flight.
- pass  out  NUM_CH  one-cycle pulse: attempt matched.
- fail  out  NUM_CH  one-cycle pulse: attempt violated.
- drop  out  NUM_CH  one-cycle pulse: start seen while busy, ignored.
- pass_cnt  out  NUM_CH*CNT_W  saturating pass count, channel i at [i*CNT_W +: CNT_W] (SEQ_CHK_STATS_EN only).
- fail_cnt  out  NUM_CH*CNT_W  saturating fail count, same packing (SEQ_CHK_STATS_EN only).

Behaviour:
- All inputs are sampled at posedge clk. All outputs are registered.
- Reset: all channels to IDLE; busy, pass, fail, drop = 0; counters = 0. Reset mid-attempt abandons the attempt with no pass/fail pulse.
- Per-channel FSM, states IDLE, XPH, YPH:
  - IDLE: start=1 -> XPH, xcnt=0, busy=1 from the next cycle.
  - XPH: x=1 -> xcnt++; on xcnt reaching X_LEN -> YPH, ycnt=0. x=0 -> fail pulse, go to IDLE.
  - YPH: y=1 -> pass pulse, go to IDLE. y=0 -> ycnt++; if ycnt reaches Y_WIN -> fail pulse, go to IDLE. x is don't-care in YPH.
- Sample timing: the first x sample is the edge after the start edge (non-overlapping implication). pass/fail is high during the cycle following the deciding edge.
- Decision/start overlap: start on the same edge the decision is taken is a drop. busy stays high through that edge. start on the next edge (FSM in IDLE) is accepted.
- drop pulses on any start sampled while in XPH or YPH. It does not disturb the running attempt.
- pass and fail are mutually exclusive per channel per cycle.
- Channels are fully independent, with no shared state.
- Counter widths: xcnt $clog2(X_LEN+1), ycnt $clog2(Y_WIN+1).

Optional Feature:
- Macro: SEQ_CHK_STATS_EN.
- Defined: pass_cnt/fail_cnt ports exist. Each increments on the edge its pulse is registered and saturates at all-ones. Cleared only by rst.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package seq_chk_pkg: state enum (IDLE, XPH, YPH), width helper functions, and parameter-legality checks (X_LEN >= 1, Y_WIN >= 1) as elaboration-time errors.
- Sub-module seq_chk_lane: one channel's FSM, counters and optional stats.
- seq_chk_multi: generate loop instantiating NUM_CH lanes and packing outputs.

Test Plan:
- Default params, ch0: start at edge E0, x=1 at E1,E2, y=1 at E3 -> pass=1 during the cycle after E3. fail never asserts. busy=1 from E0+1 through E3.
- X_LEN=3, Y_WIN=4: start E0, x high E1-E3, y=0 E4-E6, y=1 E7 -> pass after E7. Same stimulus with y never high -> fail after E7.
- Default params: start E0, x=1 E1, x=0 E2 -> fail after E2. start at E2 -> drop. start at E3 -> accepted, busy again.
- NUM_CH=4: ch1 passes and ch2 fails on the same edge, ch0/ch3 idle -> pass=4'b0010, fail=4'b0100 for exactly one cycle.
- Assert rst during XPH at E2 -> busy=0 after E2. No pass/fail for that attempt. A new start afterwards behaves as from reset.
- SEQ_CHK_STATS_EN, CNT_W=2: 5 passing attempts -> pass_cnt saturates at 3. fail_cnt stays 0.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// Shared definitions for the seq_chk_multi protocol checker.
// Provides the per-lane FSM state encodings, a counter width helper and a
// parameter legality check evaluated at elaboration.
// Optional statistics are enabled by defining SEQ_CHK_STATS_EN.
package seq_chk_pkg;

    // Per-lane FSM states: waiting for start, x repetition phase, y window phase
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XPH  = 2'd1;
    localparam logic [1:0] ST_YPH  = 2'd2;

    // Bits needed to count from 0 up to and including n
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 32'd1) ? 32'd1 : 32'($clog2(n + 32'd1));
    endfunction

    // True when the checker parameters describe a realisable sequence
    function automatic bit params_legal(input int unsigned num_ch,
                                        input int unsigned x_len,
                                        input int unsigned y_win,
                                        input int unsigned cnt_width);
        return (num_ch >= 32'd1) && (x_len >= 32'd1) && (y_win >= 32'd1)
               && (cnt_width >= 32'd1);
    endfunction

endpackage

// File: rtl/seq_chk_lane.sv
// One checker channel for "start |=> x[*X_LEN] ##[1:Y_WIN] y".
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i, x_i, y_i channel protocol inputs
//   busy_o            attempt in flight (registered)
//   pass_o, fail_o    one-cycle verdict pulses
//   drop_o            one-cycle pulse: start ignored while busy
//   pass_cnt_o, fail_cnt_o  saturating verdict counters (SEQ_CHK_STATS_EN only)
module seq_chk_lane
    import seq_chk_pkg::*;
#(
    parameter int unsigned X_LEN = 2,
    parameter int unsigned Y_WIN = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             x_i,
    input  logic             y_i,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             drop_o
`ifdef SEQ_CHK_STATS_EN
    ,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
`endif
);

    localparam int unsigned XW = cnt_w(X_LEN);
    localparam int unsigned YW = cnt_w(Y_WIN);

    if (!params_legal(32'd1, X_LEN, Y_WIN, CNT_W)) begin : g_bad_params
        $error("seq_chk_lane: X_LEN, Y_WIN and CNT_W must all be >= 1");
    end

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] xcnt_q, xcnt_d;
    logic [YW-1:0] ycnt_q, ycnt_d;
    logic          busy_q, busy_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          drop_q, drop_d;
`ifdef SEQ_CHK_STATS_EN
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            xcnt_q     <= '0;
            ycnt_q     <= '0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            drop_q     <= 1'b0;
`ifdef SEQ_CHK_STATS_EN
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            xcnt_q     <= xcnt_d;
            ycnt_q     <= ycnt_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            drop_q     <= drop_d;
`ifdef SEQ_CHK_STATS_EN
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
`endif
        end
    end

    // Next-state and verdict logic
    always_comb begin
        state_d = state_q;
        xcnt_d  = xcnt_q;
        ycnt_d  = ycnt_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        // A start while an attempt runs (including its deciding edge) is ignored
        drop_d  = start_i && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_XPH;
                    xcnt_d  = '0;
                end
            end
            ST_XPH: begin
                if (x_i) begin
                    xcnt_d = xcnt_q + XW'(1);
                    if (xcnt_d == XW'(X_LEN)) begin
                        state_d = ST_YPH;
                        ycnt_d  = '0;
                    end
                end else begin
                    fail_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_YPH: begin
                if (y_i) begin
                    pass_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ycnt_d = ycnt_q + YW'(1);
                    if (ycnt_d == YW'(Y_WIN)) begin
                        fail_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

`ifdef SEQ_CHK_STATS_EN
    // Saturating verdict counters
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (pass_d && (pass_cnt_q != '1)) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end
        if (fail_d && (fail_cnt_q != '1)) begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
        end
    end

    assign pass_cnt_o = pass_cnt_q;
    assign fail_cnt_o = fail_cnt_q;
`endif

    assign busy_o = busy_q;
    assign pass_o = pass_q;
    assign fail_o = fail_q;
    assign drop_o = drop_q;

endmodule

// File: rtl/seq_chk_multi.sv
// Multi-channel synthesizable checker for "start |=> x[*X_LEN] ##[1:Y_WIN] y".
// Each channel runs an independent seq_chk_lane.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, x, y            per-channel protocol inputs [NUM_CH]
//   busy                   per-channel attempt in flight
//   pass, fail, drop       per-channel one-cycle pulses
//   pass_cnt, fail_cnt     per-channel saturating counters, channel i at
//                          [i*CNT_W +: CNT_W] (only with SEQ_CHK_STATS_EN)
module seq_chk_multi
    import seq_chk_pkg::*;
#(
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned X_LEN  = 2,
    parameter int unsigned Y_WIN  = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       x,
    input  logic [NUM_CH-1:0]       y,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       pass,
    output logic [NUM_CH-1:0]       fail,
    output logic [NUM_CH-1:0]       drop
`ifdef SEQ_CHK_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt
`endif
);

    if (!params_legal(NUM_CH, X_LEN, Y_WIN, CNT_W)) begin : g_bad_params
        $error("seq_chk_multi: NUM_CH, X_LEN, Y_WIN and CNT_W must all be >= 1");
    end

    // One fully independent lane per channel
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        seq_chk_lane #(
            .X_LEN (X_LEN),
            .Y_WIN (Y_WIN),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .start_i    (start[i]),
            .x_i        (x[i]),
            .y_i        (y[i]),
            .busy_o     (busy[i]),
            .pass_o     (pass[i]),
            .fail_o     (fail[i]),
            .drop_o     (drop[i])
`ifdef SEQ_CHK_STATS_EN
            ,
            .pass_cnt_o (pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt_o (fail_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
